// File: rtl/display_scan_ctrl_pkg.sv
// Shared display definitions: segment/anode polarity and the active-low hex segment table.
// Used by the scan controller and by any other path that drives 7-segment digits.
package display_scan_ctrl_pkg;

   localparam logic AN_ON  = 1'b0;
   localparam logic AN_OFF = 1'b1;
   localparam logic DP_ON  = 1'b0;
   localparam logic DP_OFF = 1'b1;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // {a,b,c,d,e,f,g}, a segment is lit when its bit is 0
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between game-state logic (master) and the display scan controller (slave).
interface display_scan_ctrl_if #(
   parameter int N_DIGITS = 4
);
   // load is a one-cycle strobe with no ready: the controller captures dig_* on every
   // cycle load is high, and load_pending reports captured data not yet on the display.
   logic                  enable;
   logic                  load;
   logic [4*N_DIGITS-1:0] dig_val;
   logic [N_DIGITS-1:0]   dig_blank;
   logic [N_DIGITS-1:0]   dig_blink;
   logic [N_DIGITS-1:0]   dig_dp;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_tick;
   logic                  load_pending;

   modport master (
      output enable, load, dig_val, dig_blank, dig_blink, dig_dp,
      input  seg, dp, an, frame_tick, load_pending
   );

   modport slave (
      input  enable, load, dig_val, dig_blank, dig_blink, dig_dp,
      output seg, dp, an, frame_tick, load_pending
   );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with double-buffered loading and blink.
// Build option DISPLAY_DEADTIME_EN: anodes dark for the first 2 cycles of each digit slot.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input logic              clk,
   input logic              rst_n,
   display_scan_ctrl_if.slave bus
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PW = $clog2(PRESCALE);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef struct packed {
      logic [4*N_DIGITS-1:0] val;
      logic [N_DIGITS-1:0]   blank;
      logic [N_DIGITS-1:0]   blink;
      logic [N_DIGITS-1:0]   dp;
   } digbuf_t;

   localparam digbuf_t BUF_RST = '{val: '0, blank: '1, blink: '0, dp: '0};

   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   digbuf_t             active_q, active_d;
   digbuf_t             pending_q, pending_d;
   logic                pend_q, pend_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic                ft_q, ft_d;

   logic                tc, boundary, dark;
   logic [3:0]          cur_nib;
   logic [6:0]          dec_seg;
   digbuf_t             in_buf;

   assign cur_nib = active_q.val[{idx_q, 2'b00} +: 4];

   seg7_hex_decoder u_dec (
      .nibble_i (cur_nib),
      .seg_o    (dec_seg)
   );

   always_comb begin
      presc_d       = presc_q;
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      active_d      = active_q;
      pending_d     = pending_q;
      pend_d        = pend_q;
      in_buf        = '{val: bus.dig_val, blank: bus.dig_blank,
                        blink: bus.dig_blink, dp: bus.dig_dp};

      tc       = bus.enable && (presc_q == PW'(PRESCALE - 1));
      boundary = tc && (idx_q == IW'(N_DIGITS - 1));

      if (!bus.enable) begin
         presc_d     = '0;
         idx_d       = '0;
         blink_cnt_d = '0;
      end else if (tc) begin
         presc_d = '0;
         idx_d   = boundary ? '0 : idx_q + IW'(1);
      end else begin
         presc_d = presc_q + PW'(1);
      end

      if (boundary) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end

      // A load landing on the boundary bypasses the pending buffer entirely.
      if (bus.load && boundary) begin
         active_d  = in_buf;
         pending_d = in_buf;
         pend_d    = 1'b0;
      end else if (bus.load) begin
         pending_d = in_buf;
         pend_d    = 1'b1;
      end else if (boundary && pend_q) begin
         active_d = pending_q;
         pend_d   = 1'b0;
      end
   end

   always_comb begin
      an_d  = {N_DIGITS{AN_OFF}};
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      ft_d  = boundary;
      dark  = active_q.blank[idx_q] | (active_q.blink[idx_q] & blink_phase_q);
      if (bus.enable) begin
         an_d[idx_q] = AN_ON;
`ifdef DISPLAY_DEADTIME_EN
         if (presc_q <= PW'(1)) an_d = {N_DIGITS{AN_OFF}};
`endif
         if (!dark) begin
            seg_d = dec_seg;
            dp_d  = ~active_q.dp[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q       <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         active_q      <= BUF_RST;
         pending_q     <= BUF_RST;
         pend_q        <= 1'b0;
         seg_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
         an_q          <= {N_DIGITS{AN_OFF}};
         ft_q          <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         pend_q        <= pend_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         ft_q          <= ft_d;
      end
   end

   assign bus.seg          = seg_q;
   assign bus.dp           = dp_q;
   assign bus.an           = an_q;
   assign bus.frame_tick   = ft_q;
   assign bus.load_pending = pend_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Parametrised N-digit 7-segment scan controller for the board display. It replaces external 2-bit counter scanning with an internal prescaler and digit counter.
- Adds tear-free double-buffered loading, per-digit blank/blink/decimal-point and a frame tick.
- Sits between game-state logic (mode, life, coordinates, map, already reduced to hex nibbles) and the board's segment/anode pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles per digit slot (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  0 = display off (all anodes/segments off, counters held at 0).
- load  input  1  one-cycle strobe; capture the dig_* inputs into the pending buffer.
- dig_val  input  4*N_DIGITS  hex nibble per digit; digit i is bits [4i+3:4i].
- dig_blank  input  N_DIGITS  1 = digit i dark.
- dig_blink  input  N_DIGITS  1 = digit i blinks.
- dig_dp  input  N_DIGITS  1 = decimal point lit on digit i.
- seg  output  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  N_DIGITS  digit anodes, active-low, one-hot-low when active.
- frame_tick  output  1  one-cycle pulse when the digit index wraps N_DIGITS-1 -> 0.
- load_pending  output  1  high from a load until the pending data becomes active.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, idx=0, blink counter=0, blink_phase=0.
  - Active and pending buffers cleared; all blank bits set.
  - seg=7'h7F, dp=1, an=all 1, frame_tick=0, load_pending=0.
- Prescaler: counts 0..PRESCALE-1. At terminal count (tc) it returns to 0 and idx advances by 1. idx wraps N_DIGITS-1 -> 0.
- Frame boundary: tc while idx=N_DIGITS-1. frame_tick=1 in the cycle after the boundary edge, for exactly one cycle.
- Load:
  - load=1 captures all dig_* inputs into pending and sets load_pending.
  - At the next frame boundary, pending is copied to active and load_pending clears.
  - If load coincides with a boundary, the newly presented inputs go directly to active and load_pending stays 0.
  - A second load before the boundary overwrites pending; last write wins.
- Blink: the blink counter increments on each frame boundary. At BLINK_FRAMES-1 it returns to 0 and blink_phase toggles. A digit is dark when blank | (blink & blink_phase).
- Output stage, registered (1-cycle latency after idx changes):
  - an[idx]=0, all other anode bits 1.
  - seg = hex decode of active nibble[idx], forced to 7'h7F if the digit is dark.
  - dp = ~dp_bit[idx], forced to 1 if the digit is dark.
- Hex decode, {a..g} active-low:
  - Digits: 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04.
  - Letters: A=08, b=60, C=31, d=42, E=30, F=38.
- enable=0:
  - Next cycle: an=all 1, seg=7F, dp=1, frame_tick=0.
  - prescaler, idx and blink counter are held at 0.
  - load still captures into pending. A pending load is applied at the first boundary after re-enable.
- enable 0 -> 1: idx 0 is displayed from the next cycle.
- rst_n low mid-frame: reset values apply on that edge; pending data is discarded.

Optional Feature:
- DISPLAY_DEADTIME_EN defined:
  - an is forced to all 1 for the first 2 clk cycles of each digit slot (prescaler < 2). This suppresses ghosting.
  - seg/dp still update on the normal schedule.
- Not defined: an is driven for the full slot.

Decomposition:
- Shared include/package display_defs:
  - SEG_OFF (7'h7F).
  - The 16-entry hex segment constants.
  - Anode/segment polarity localparams.
- Sub-module seg7_hex_decoder: combinational, 4-bit nibble -> 7-bit active-low segments. It is reused by other display paths.
- Scan index width is $clog2(N_DIGITS) computed locally.

Test Plan:
- Reset then idle, PRESCALE=4, N_DIGITS=4, enable=1 -> all digits dark. an cycles 1110, 1101, 1011, 0111 every 4 clk. frame_tick pulses every 16 clk.
- load with dig_val=16'h3A90, dig_blank=0 mid-frame -> load_pending=1 until the boundary. Afterwards the slot with an=1110 shows seg=01 ('0'), an=1101 shows 04 ('9'), an=1011 shows 08 ('A'), an=0111 shows 06 ('3').
- load twice before a boundary (16'h1111 then 16'h2222) -> only 2 (seg=12) is ever shown. load exactly on the boundary cycle -> new data appears in the next frame with load_pending never asserted.
- BLINK_FRAMES=2, dig_blink=4'b0001 -> digit 0 is lit for frames 0-1, dark (seg=7F, dp=1) for frames 2-3, then repeats. Other digits are unaffected.
- enable dropped mid-slot -> next cycle an=1111, seg=7F. enable raised -> an=1110 the following cycle, and the prescaler restarts at 0.
- With DISPLAY_DEADTIME_EN: an=1111 for the first 2 cycles of every slot, then the digit's anode is low for the remaining PRESCALE-2 cycles. rst_n=0 mid-slot -> all outputs at their reset values after that edge.
